// File: rtl/uart_word_assembler.sv
// ============================================================================
// Module   : uart_word_assembler
// Purpose  : Packs received UART bytes into BYTES_PER_WORD-byte words with a
//            valid/ready output, overrun and timeout pulses and error tagging.
// Options  : UART_WORD_ERROR_DISCARD_EN - erroneous bytes flush the partial
//            word and pulse o_word_error instead of tagging the completed word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_assembler #(
   parameter int BYTES_PER_WORD = 2,
   parameter int LSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    i_data_in,
   input  logic                          i_valid,
   input  logic                          i_ferror,
   input  logic                          i_perror,
   input  logic                          i_clear,
   input  logic                          i_word_ready,
   output logic [8*BYTES_PER_WORD-1:0]   o_word_out,
   output logic                          o_word_valid,
   output logic                          o_word_error,
   output logic [3:0]                    o_byte_count,
   output logic                          o_overrun,
   output logic                          o_timeout
);

   localparam int          c_WORD_W    = 8 * BYTES_PER_WORD;
   localparam logic [3:0]  c_LAST_SLOT = 4'(BYTES_PER_WORD - 1);
   localparam logic [15:0] c_TIMEOUT   = 16'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      S_EMPTY   = 1'b0,
      S_FILLING = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_WORD_W-1:0]   r_buf;
   logic [3:0]            r_cnt;
   logic                  r_err_acc;
   logic [15:0]           r_idle;
   logic [c_WORD_W-1:0]   r_word_out;
   logic                  r_word_valid;
   logic                  r_word_error;
   logic                  r_overrun;
   logic                  r_timeout;

   logic                  w_byte_err;
   logic                  w_last;
   logic                  w_out_free;
   logic                  w_timeout_hit;
   logic [3:0]            w_slot;
   logic [c_WORD_W-1:0]   w_buf_ins;

   assign w_byte_err    = i_ferror | i_perror;
   assign w_last        = (r_cnt == c_LAST_SLOT);
   // A register being drained on this edge is as good as empty.
   assign w_out_free    = ~r_word_valid | i_word_ready;
   assign w_slot        = (LSB_FIRST != 0) ? r_cnt : (c_LAST_SLOT - r_cnt);
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && ((r_idle + 16'd1) == c_TIMEOUT);

   always_comb begin
      w_buf_ins = r_buf;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (w_slot == 4'(k)) begin
            w_buf_ins[8*k +: 8] = i_data_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_EMPTY;
         r_buf        <= '0;
         r_cnt        <= 4'd0;
         r_err_acc    <= 1'b0;
         r_idle       <= 16'd0;
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
         r_word_error <= 1'b0;
         r_overrun    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;

         if (r_word_valid && i_word_ready) begin
            r_word_valid <= 1'b0;
            r_word_error <= 1'b0;
         end
`ifdef UART_WORD_ERROR_DISCARD_EN
         r_word_error <= 1'b0;
`endif

         if (i_clear) begin
            r_state   <= S_EMPTY;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_err_acc <= 1'b0;
            r_idle    <= 16'd0;
`ifdef UART_WORD_ERROR_DISCARD_EN
         end else if (i_valid && w_byte_err) begin
            r_state      <= S_EMPTY;
            r_buf        <= '0;
            r_cnt        <= 4'd0;
            r_err_acc    <= 1'b0;
            r_idle       <= 16'd0;
            r_word_error <= 1'b1;
`endif
         end else if (i_valid) begin
            r_idle <= 16'd0;
            if (w_last) begin
               if (w_out_free) begin
                  r_word_out   <= w_buf_ins;
                  r_word_valid <= 1'b1;
                  r_word_error <= r_err_acc | w_byte_err;
               end else begin
                  r_overrun <= 1'b1;
               end
               r_state   <= S_EMPTY;
               r_buf     <= '0;
               r_cnt     <= 4'd0;
               r_err_acc <= 1'b0;
            end else begin
               r_state   <= S_FILLING;
               r_buf     <= w_buf_ins;
               r_cnt     <= r_cnt + 4'd1;
               r_err_acc <= r_err_acc | w_byte_err;
            end
         end else if (r_state == S_FILLING) begin
            if (w_timeout_hit) begin
               r_state   <= S_EMPTY;
               r_buf     <= '0;
               r_cnt     <= 4'd0;
               r_err_acc <= 1'b0;
               r_idle    <= 16'd0;
               r_timeout <= 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               r_idle <= r_idle + 16'd1;
            end
         end
      end
   end

   assign o_word_out   = r_word_out;
   assign o_word_valid = r_word_valid;
   assign o_word_error = r_word_error;
   assign o_byte_count = r_cnt;
   assign o_overrun    = r_overrun;
   assign o_timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_assembler.sv
// ============================================================================
// Module   : tb_uart_word_assembler
// Purpose  : Directed self-checking bench for uart_word_assembler using three
//            parameterisations driven from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_word_assembler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  i_data_in = 8'h00;
   logic        i_valid = 1'b0;
   logic        i_ferror = 1'b0;
   logic        i_perror = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_word_ready = 1'b0;

   wire [15:0]  a_word;  wire a_wv, a_we, a_ov, a_to;  wire [3:0] a_bc;
   wire [31:0]  b_word;  wire b_wv, b_we, b_ov, b_to;  wire [3:0] b_bc;
   wire [15:0]  c_word;  wire c_wv, c_we, c_ov, c_to;  wire [3:0] c_bc;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_word_assembler #(.BYTES_PER_WORD(2), .LSB_FIRST(1), .TIMEOUT_CYCLES(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_data_in(i_data_in), .i_valid(i_valid),
      .i_ferror(i_ferror), .i_perror(i_perror), .i_clear(i_clear),
      .i_word_ready(i_word_ready), .o_word_out(a_word), .o_word_valid(a_wv),
      .o_word_error(a_we), .o_byte_count(a_bc), .o_overrun(a_ov), .o_timeout(a_to));

   uart_word_assembler #(.BYTES_PER_WORD(4), .LSB_FIRST(0), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_data_in(i_data_in), .i_valid(i_valid),
      .i_ferror(i_ferror), .i_perror(i_perror), .i_clear(i_clear),
      .i_word_ready(i_word_ready), .o_word_out(b_word), .o_word_valid(b_wv),
      .o_word_error(b_we), .o_byte_count(b_bc), .o_overrun(b_ov), .o_timeout(b_to));

   uart_word_assembler #(.BYTES_PER_WORD(2), .LSB_FIRST(1), .TIMEOUT_CYCLES(10)) dut_c (
      .clk(clk), .rst_n(rst_n), .i_data_in(i_data_in), .i_valid(i_valid),
      .i_ferror(i_ferror), .i_perror(i_perror), .i_clear(i_clear),
      .i_word_ready(i_word_ready), .o_word_out(c_word), .o_word_valid(c_wv),
      .o_word_error(c_we), .o_byte_count(c_bc), .o_overrun(c_ov), .o_timeout(c_to));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic pe);
      i_data_in = d;
      i_valid   = 1'b1;
      i_perror  = pe;
      tick();
      i_valid   = 1'b0;
      i_perror  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({a_word, a_wv, a_we, a_bc, a_ov, a_to} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_a: got %h want 0", {a_word, a_wv, a_we, a_bc, a_ov, a_to});
      end
      n_vec++;
      if ({b_word, b_wv, b_we, b_bc, b_ov, b_to} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_b: got %h want 0", {b_word, b_wv, b_we, b_bc, b_ov, b_to});
      end
   endtask

   task automatic test_lsb_word();
      do_reset();
      i_word_ready = 1'b1;
      send(8'h34, 1'b0);
      n_vec++;
      if (a_bc !== 4'd1 || a_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL lsb_first_byte: got bc=%0d wv=%b want bc=1 wv=0", a_bc, a_wv);
      end
      send(8'h12, 1'b0);
      n_vec++;
      if (a_word !== 16'h1234 || a_wv !== 1'b1 || a_we !== 1'b0 || a_bc !== 4'd0) begin
         n_fail++;
         $display("FAIL lsb_word: got %h wv=%b we=%b bc=%0d want 1234 1 0 0", a_word, a_wv, a_we, a_bc);
      end
      tick();
      n_vec++;
      if (a_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL lsb_drain: got wv=%b want 0", a_wv);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      i_word_ready = 1'b0;
      send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
      n_vec++;
      if (b_word !== 32'hDEADBEEF || b_wv !== 1'b1) begin
         n_fail++;
         $display("FAIL msb_word: got %h wv=%b want deadbeef 1", b_word, b_wv);
      end
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      n_vec++;
      if (b_ov !== 1'b0 || b_bc !== 4'd3) begin
         n_fail++;
         $display("FAIL pre_overrun: got ov=%b bc=%0d want 0 3", b_ov, b_bc);
      end
      send(8'h04, 1'b0);
      n_vec++;
      if (b_ov !== 1'b1 || b_word !== 32'hDEADBEEF || b_bc !== 4'd0) begin
         n_fail++;
         $display("FAIL overrun: got ov=%b word=%h bc=%0d want 1 deadbeef 0", b_ov, b_word, b_bc);
      end
      tick();
      n_vec++;
      if (b_ov !== 1'b0 || b_wv !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_pulse: got ov=%b wv=%b want 0 1", b_ov, b_wv);
      end
      i_word_ready = 1'b1;
      tick();
      n_vec++;
      if (b_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_drain: got wv=%b want 0", b_wv);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_word_ready = 1'b0;
      send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0);
      i_word_ready = 1'b1;
      send(8'hD4, 1'b0);
      n_vec++;
      if (a_word !== 16'hD4C3 || a_wv !== 1'b1 || a_ov !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_and_load: got %h wv=%b ov=%b want d4c3 1 0", a_word, a_wv, a_ov);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      i_word_ready = 1'b1;
      send(8'hAA, 1'b0);
      repeat (9) tick();
      n_vec++;
      if (c_bc !== 4'd1 || c_to !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: got bc=%0d to=%b want 1 0", c_bc, c_to);
      end
      tick();
      n_vec++;
      if (c_bc !== 4'd0 || c_to !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_fire: got bc=%0d to=%b want 0 1", c_bc, c_to);
      end
      tick();
      n_vec++;
      if (c_to !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: got to=%b want 0", c_to);
      end
      send(8'h01, 1'b0); send(8'h02, 1'b0);
      n_vec++;
      if (c_word !== 16'h0201 || c_wv !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_reuse: got %h wv=%b want 0201 1", c_word, c_wv);
      end
   endtask

   task automatic test_error_tag();
      do_reset();
      i_word_ready = 1'b1;
      send(8'h55, 1'b1);
`ifdef UART_WORD_ERROR_DISCARD_EN
      n_vec++;
      if (a_bc !== 4'd0 || a_we !== 1'b1 || a_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL err_discard: got bc=%0d we=%b wv=%b want 0 1 0", a_bc, a_we, a_wv);
      end
      send(8'h66, 1'b0);
      n_vec++;
      if (a_bc !== 4'd1 || a_we !== 1'b0 || a_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL err_after: got bc=%0d we=%b wv=%b want 1 0 0", a_bc, a_we, a_wv);
      end
`else
      n_vec++;
      if (a_bc !== 4'd1 || a_we !== 1'b0) begin
         n_fail++;
         $display("FAIL err_store: got bc=%0d we=%b want 1 0", a_bc, a_we);
      end
      send(8'h66, 1'b0);
      n_vec++;
      if (a_word !== 16'h6655 || a_wv !== 1'b1 || a_we !== 1'b1) begin
         n_fail++;
         $display("FAIL err_tag: got %h wv=%b we=%b want 6655 1 1", a_word, a_wv, a_we);
      end
      tick();
      n_vec++;
      if (a_wv !== 1'b0 || a_we !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: got wv=%b we=%b want 0 0", a_wv, a_we);
      end
`endif
   endtask

   task automatic test_clear_and_reset();
      do_reset();
      i_word_ready = 1'b0;
      send(8'h11, 1'b0);
      i_clear = 1'b1;
      send(8'h22, 1'b0);
      i_clear = 1'b0;
      n_vec++;
      if (a_bc !== 4'd0 || a_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_wins: got bc=%0d wv=%b want 0 0", a_bc, a_wv);
      end
      send(8'h33, 1'b0); send(8'h44, 1'b0);
      n_vec++;
      if (a_word !== 16'h4433 || a_wv !== 1'b1) begin
         n_fail++;
         $display("FAIL after_clear: got %h wv=%b want 4433 1", a_word, a_wv);
      end
      send(8'h77, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({a_word, a_wv, a_we, a_bc, a_ov, a_to} !== 24'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want 0", {a_word, a_wv, a_we, a_bc, a_ov, a_to});
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lsb_word();
      test_overrun();
      test_back_to_back();
      test_timeout();
      test_error_tag();
      test_clear_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Packs a stream of received UART bytes into BYTES_PER_WORD-byte words, sitting between the UART receiver and downstream consumers such as the LED/display logic.
- Fully synchronous to clk; the receiver's valid, ferror and perror are sampled as single-cycle strobes.
- Adds:
  - selectable byte order
  - a valid/ready output handshake with overrun detection
  - per-word error tagging
  - an inter-byte timeout that discards stale partial words.

Parameters:
- BYTES_PER_WORD, 2, bytes per output word; legal 2..8
- LSB_FIRST, 1, 1: first byte lands in word_out[7:0]; 0: first byte lands in the top byte
- TIMEOUT_CYCLES, 0, clk cycles allowed between bytes of one word before the partial word is discarded; 0 disables; legal 0..65535

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  8  received byte
- valid  in  1  one-cycle strobe; data_in, ferror and perror are valid while high
- ferror  in  1  framing error for the current byte
- perror  in  1  parity error for the current byte
- clear  in  1  synchronous flush of the partial word; the output register is unaffected
- word_ready  in  1  consumer accepts word_out
- word_out  out  8*BYTES_PER_WORD  assembled word
- word_valid  out  1  word_out holds an unconsumed word
- word_error  out  1  at least one byte of word_out had ferror or perror set
- byte_count  out  4  bytes held in the partial word
- overrun  out  1  one-cycle pulse: a completed word was dropped
- timeout  out  1  one-cycle pulse: a partial word was discarded by timeout

Behaviour:
- Reset (reset=0, asynchronous): every register and output is 0. State is EMPTY.
- FSM states:
  - EMPTY: byte_count=0.
  - FILLING: 0<byte_count<BYTES_PER_WORD.
- Byte accept: on a clk edge with valid=1, data_in is written into byte slot byte_count.
  - LSB_FIRST=1: slot k is bits [8k+7:8k].
  - LSB_FIRST=0: slot k is bits [8(N-1-k)+7:8(N-1-k)].
  - byte_count increments.
  - A sticky err_acc bit is ORed with (ferror|perror).
- Transitions:
  - EMPTY --valid--> FILLING.
  - FILLING --valid, last slot--> EMPTY, with word completion.
  - FILLING --clear or timeout--> EMPTY.
- Word completion happens on the edge that accepts byte N:
  - If the output register is free, or is draining on that same edge (word_valid & word_ready), then word_out, word_error=err_acc|current error and word_valid=1 are registered on that edge. Latency is 1 clk from the final valid sample to word_valid.
  - Otherwise the completed word is dropped, overrun pulses for 1 cycle, and word_out is unchanged.
  - In both cases the assembly buffer, err_acc and byte_count reset to 0.
- Output handshake:
  - word_valid stays high until a clk edge with word_ready=1, then clears unless a new word loads on the same edge.
  - word_out is stable while word_valid=1.
  - word_error clears together with word_valid.
- Timeout (TIMEOUT_CYCLES>0):
  - A 16-bit idle counter runs only in FILLING, increments every clk without valid, and is zeroed on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: byte_count and err_acc go to 0, state goes to EMPTY, timeout pulses for 1 cycle.
  - In EMPTY the counter is held at 0.
- Simultaneous events:
  - clear and valid on the same edge: clear wins, the byte is dropped, result is EMPTY.
  - Timeout expiry and valid on the same edge: valid wins, the byte is accepted and the counter restarts.
  - A completion that is also an overrun with word_ready=1: the word loads, because a draining register counts as free.
- Asynchronous reset mid-word: all state clears immediately; no pulses are generated.
- Bytes beyond the width are impossible; byte_count never exceeds BYTES_PER_WORD-1.

Optional Feature:
- Macro: UART_WORD_ERROR_DISCARD_EN.
- Defined: a byte with ferror|perror is not stored. The partial word is discarded (byte_count=0, EMPTY), and word_error pulses for 1 cycle while word_valid stays unaffected. In this build, completed words never carry an error tag.
- Undefined: erroneous bytes are stored normally and tagged through word_error on the completed word, as described in Behaviour.

Test Plan:
- N=2, LSB_FIRST=1, word_ready=1; bytes 0x34 then 0x12 -> word_out=0x1234, word_valid high exactly 1 cycle after the second valid, word_error=0.
- N=4, LSB_FIRST=0; bytes 0xDE,0xAD,0xBE,0xEF with word_ready=0 -> word_out=0xDEADBEEF held; then 4 more bytes -> overrun pulses once and word_out stays 0xDEADBEEF; assert word_ready -> word_valid drops.
- N=2, TIMEOUT_CYCLES=10; byte 0xAA then 10 idle cycles -> timeout pulses and byte_count=0; then bytes 0x01,0x02 -> word_out=0x0201.
- N=2; byte 0x55 with perror=1 then 0x66 -> word_out=0x6655, word_error=1 (macro undefined); with macro defined -> word_error pulse, byte_count=0, and no word from the 0x66.
- Byte 0x11, then clear and valid with 0x22 on the same edge -> byte_count=0, no word; reset driven low mid-word -> all outputs 0 at once.
